// File: rtl/sram_axi_bridge_mp.sv
// Multi-port SRAM-like to AXI3 master bridge.
// Single-beat reads and writes. Reads go through one AR holding register, and each port
// may have up to MAX_OUT reads outstanding. One write is in flight at a time, under a
// small write FSM. A read is held back while a write to the same word is still pending.
// Define BRIDGE_RR_ARB_EN to get round-robin arbitration. Without it, arbitration is
// fixed priority and the lowest index wins.
module sram_axi_bridge_mp #(
    parameter int unsigned NPORT   = 2,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NPORT-1:0]     port_req,
    input  logic [NPORT-1:0]     port_wr,
    input  logic [2*NPORT-1:0]   port_size,
    input  logic [32*NPORT-1:0]  port_addr,
    input  logic [4*NPORT-1:0]   port_wstrb,
    input  logic [32*NPORT-1:0]  port_wdata,
    output logic [NPORT-1:0]     port_addr_ok,
    output logic [NPORT-1:0]     port_data_ok,
    output logic [31:0]          port_rdata,
    output logic [3:0]           arid,
    output logic [31:0]          araddr,
    output logic [3:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic [1:0]           arlock,
    output logic [3:0]           arcache,
    output logic [2:0]           arprot,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [3:0]           rid,
    input  logic [31:0]          rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [3:0]           awid,
    output logic [31:0]          awaddr,
    output logic [3:0]           awlen,
    output logic [2:0]           awsize,
    output logic [1:0]           awburst,
    output logic [1:0]           awlock,
    output logic [3:0]           awcache,
    output logic [2:0]           awprot,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [3:0]           wid,
    output logic [31:0]          wdata,
    output logic [3:0]           wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [3:0]           bid,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready
);

    localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_e;

    w_state_e         w_state_q;
    logic [NPORT-1:0] cand;
    logic [31:0]      addr_a  [NPORT];
    logic [1:0]       size_a  [NPORT];
    logic [3:0]       strb_a  [NPORT];
    logic [31:0]      wdata_a [NPORT];
    logic [PW-1:0]    win, idx;
    logic             found, rd_grant, wr_grant;
    logic             ar_valid_q, aw_valid_q, w_valid_q;
    logic [3:0]       arid_q, awid_q, wstrb_q;
    logic [31:0]      araddr_q, awaddr_q, wdata_q;
    logic [1:0]       arsize_q, awsize_q;

    // Responses carry no information the ports can use.
    logic unused_resp;
    assign unused_resp = ^{rresp, rlast, bresp};

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic          hazard, inc, dec;
        logic [CW-1:0] cnt_q;

        assign addr_a[p]  = port_addr[32*p +: 32];
        assign size_a[p]  = port_size[2*p +: 2];
        assign strb_a[p]  = port_wstrb[4*p +: 4];
        assign wdata_a[p] = port_wdata[32*p +: 32];

        // Read-after-write on the same word while the write is not yet acknowledged.
        assign hazard  = (w_state_q != W_IDLE) && (addr_a[p][31:2] == awaddr_q[31:2]);
        assign cand[p] = port_req[p] && (port_wr[p] ? (w_state_q == W_IDLE)
                       : (!ar_valid_q && (cnt_q < CW'(MAX_OUT)) && !hazard));
        assign port_data_ok[p] = (rvalid && (rid == 4'(p))) || (bvalid && (bid == 4'(p)));

        assign inc = rd_grant && (win == PW'(p));
        assign dec = rvalid && (rid == 4'(p)) && (cnt_q != '0);

        // Outstanding-read counter; a grant and a return in the same cycle cancel out.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                cnt_q <= '0;
            end else if (inc && !dec) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (dec && !inc) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

`ifdef BRIDGE_RR_ARB_EN
    logic [PW-1:0] rr_ptr_q;

    // The pointer moves to the port after the winner, so the winner gets lowest priority next.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr_q <= '0;
        end else if (found) begin
            rr_ptr_q <= (win == PW'(NPORT - 1)) ? '0 : win + PW'(1);
        end
    end
`endif

    // Pick the first candidate, starting at the pointer (round-robin) or at port 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < int'(NPORT); i++) begin
`ifdef BRIDGE_RR_ARB_EN
            idx = PW'((int'(rr_ptr_q) + i) % int'(NPORT));
`else
            idx = PW'(i);
`endif
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Grant is combinational and suppressed while reset is asserted.
    always_comb begin
        port_addr_ok = '0;
        if (found && aresetn) begin
            port_addr_ok[win] = 1'b1;
        end
    end

    assign rd_grant = found && aresetn && !port_wr[win];
    assign wr_grant = found && aresetn && port_wr[win];

    // AR holding register: filled on a read grant, emptied by the AR handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_valid_q <= 1'b0;
            arid_q     <= '0;
            araddr_q   <= '0;
            arsize_q   <= '0;
        end else if (rd_grant) begin
            ar_valid_q <= 1'b1;
            arid_q     <= 4'(win);
            araddr_q   <= addr_a[win];
            arsize_q   <= size_a[win];
        end else if (ar_valid_q && arready) begin
            ar_valid_q <= 1'b0;
        end
    end

    // Write FSM: AW and W drop independently on their own handshake, then wait for B.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q  <= W_IDLE;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            awid_q     <= '0;
            awaddr_q   <= '0;
            awsize_q   <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: if (wr_grant) begin
                    w_state_q  <= W_REQ;
                    aw_valid_q <= 1'b1;
                    w_valid_q  <= 1'b1;
                    awid_q     <= 4'(win);
                    awaddr_q   <= addr_a[win];
                    awsize_q   <= size_a[win];
                    wstrb_q    <= strb_a[win];
                    wdata_q    <= wdata_a[win];
                end
                W_REQ: begin
                    if (awready) aw_valid_q <= 1'b0;
                    if (wready) w_valid_q <= 1'b0;
                    if ((!aw_valid_q || awready) && (!w_valid_q || wready)) begin
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: if (bvalid) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, arsize_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = ar_valid_q;
    assign rready  = 1'b1;

    assign awid    = awid_q;
    assign awaddr  = awaddr_q;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, awsize_q};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = aw_valid_q;

    assign wid     = awid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = w_valid_q;
    assign bready  = 1'b1;

    assign port_rdata = rdata;

endmodule

// File: doc/sram_axi_bridge_mp.md
SRAM_AXI_BRIDGE_MP -- requirements
Module: sram_axi_bridge_mp

Interface
REQ-001 SHALL have parameter NPORT, default 2, number of SRAM-like request ports (1..4); port p uses bits [p*W +: W] of each packed bus.
REQ-002 SHALL have parameter MAX_OUT, default 2, maximum outstanding reads per port (1..7).
REQ-003 SHALL use one clock; reset is asynchronous and active-low (aclk, aresetn), listed first:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
REQ-004 SHALL provide these per-port ports:
- port_req  in  NPORT  request
- port_wr  in  NPORT  1=write
- port_size  in  2*NPORT  0/1/2 = 1/2/4 bytes
- port_addr  in  32*NPORT  byte address
- port_wstrb  in  4*NPORT  byte strobes
- port_wdata  in  32*NPORT  write data
- port_addr_ok  out  NPORT  request accepted
- port_data_ok  out  NPORT  read data / write done pulse
- port_rdata  out  32  read data, shared by all ports
REQ-005 SHALL provide the full AXI3 AR, R, AW, W and B master channels (arid..arvalid/arready, rid/rdata/rresp/rlast/rvalid/rready, awid..awvalid/awready, wid/wdata/wstrb/wlast/wvalid/wready, bid/bresp/bvalid/bready), 4-bit IDs, 32-bit address/data.

Function
REQ-006 SHALL tie arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, wlast=1, wid=awid, rready=1, bready=1; arsize/awsize={1'b0,size}.
REQ-007 SHALL set arid/awid to the granted port index, zero-extended.
REQ-008 SHALL grant at most one port per cycle; a port is a candidate iff req=1 and either (wr=1 and write FSM in W_IDLE) or (wr=0, AR register empty, port outstanding count < MAX_OUT, no RAW hazard).
REQ-009 SHALL drive port_addr_ok[p] combinationally, same cycle as grant; the request fields are captured at that clock edge.
REQ-010 SHALL register a granted read into the AR register; arvalid=1 from the next cycle, held with stable fields until arready; the register is empty again in the cycle after the handshake.
REQ-011 SHALL run a write FSM: W_IDLE -> (grant of a write) -> W_REQ, with awvalid=wvalid=1; each drops independently on its own handshake; both done -> W_RESP; bvalid -> W_IDLE.
REQ-012 SHALL accept awready and wready in the same or in different cycles, in either order.
REQ-013 SHALL flag a RAW hazard when the write FSM is not W_IDLE and read addr[31:2] equals the latched write addr[31:2]; the read is not granted until the FSM returns to W_IDLE.
REQ-014 SHALL keep a per-port outstanding-read counter:
- +1 on a read grant
- -1 on rvalid with rid==p
- unchanged when both occur in the same cycle
REQ-015 SHALL drive port_data_ok[p] = (rvalid && rid==p) || (bvalid && bid==p) combinationally; port_rdata = rdata.
REQ-016 SHALL return reads to each port in issue order (AXI same-ID ordering); rresp and bresp are ignored.

Reset
REQ-017 SHALL, on aresetn=0, asynchronously clear arvalid, awvalid, wvalid, all counters, the AR register and the round-robin pointer, and force the write FSM to W_IDLE.
REQ-018 SHALL drive port_addr_ok=0 during reset; a transaction in flight when reset asserts is abandoned with no data_ok.

Configuration
REQ-019 SHALL support macro BRIDGE_RR_ARB_EN:
- defined: round-robin arbitration; the pointer advances to (winner+1) mod NPORT after each grant, and the search starts at the pointer.
- undefined: fixed priority, lowest index wins; no pointer register.

Verification
REQ-020 Port0 read 0x1C000000, arready delayed 3 cycles, rdata=0xDEADBEEF -> one AR with arid=0; port_data_ok[0] pulses with port_rdata=0xDEADBEEF.
REQ-021 Port1 write addr 0x100, wstrb=4'b0011; wready arrives 2 cycles before awready -> single AW and single W; port_data_ok[1] on bvalid with bid=1.
REQ-022 Write 0x200 pending, port0 reads 0x203 -> no addr_ok until bvalid; read issued next cycle after; a read of 0x204 in the same situation is granted immediately.
REQ-023 MAX_OUT=2, three back-to-back port0 reads, R withheld -> third addr_ok only after first rvalid with rid=0.
REQ-024 Both ports requesting reads every cycle, BRIDGE_RR_ARB_EN defined -> grants alternate 0,1,0,1; undefined -> port0 always wins.
REQ-025 aresetn dropped while arvalid=1 and write FSM in W_RESP -> arvalid/awvalid/wvalid fall immediately; counters 0 and FSM W_IDLE after release.
